// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
package run_ctrl_pkg;

    // Controller phases: hold everything in reset, stagger the channel
    // releases, run until halt or the cycle limit, then park in a result state.
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam int unsigned DEF_N_CH     = 2;
    localparam int unsigned DEF_HOLD_CYC = 4;
    localparam int unsigned DEF_STAGGER  = 2;
    localparam int unsigned DEF_MAX_CYC  = 500;
    localparam int unsigned DEF_CW       = 32;

endpackage : run_ctrl_pkg

// File: rtl/run_ctrl.sv
// Run controller: holds N_CH reset channels for HOLD_CYC cycles, releases
// them STAGGER cycles apart, then counts RUN cycles until halt_i or the
// MAX_CYC limit. start re-arms the sequence from DONE or TIMEOUT.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned N_CH     = DEF_N_CH,
    parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
    parameter int unsigned STAGGER  = DEF_STAGGER,
    parameter int unsigned MAX_CYC  = DEF_MAX_CYC,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_i,
    output logic [N_CH-1:0] rst_o,
    output logic            running,
    output logic            done,
    output logic            timeout,
    output logic [CW-1:0]   cycle_cnt
);

    // The shared counter must cover both the hold phase and the full stagger span.
    localparam int unsigned REL_SPAN = (N_CH - 1) * STAGGER;
    localparam int unsigned CNT_MAX  = (HOLD_CYC > REL_SPAN) ? HOLD_CYC : REL_SPAN;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_SPAN);
    localparam logic [CW-1:0]    CYC_LAST  = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0]    CYC_LIMIT = CW'(MAX_CYC);

    // Reject a cycle counter too narrow to reach MAX_CYC without wrapping.
    if (CW < $clog2(MAX_CYC + 1)) begin : g_cw_check
        $error("run_ctrl: CW is too narrow to hold MAX_CYC");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [N_CH-1:0]   rst_q, rst_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [N_CH-1:0]   rel_hit;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Channel 0 is released on the HOLD exit edge, never from RELEASE.
    assign rel_hit[0] = 1'b0;

    // Channel gi (gi >= 1) releases on the RELEASE edge that brings the counter to gi*STAGGER.
    for (genvar gi = 1; gi < N_CH; gi++) begin : g_rel_hit
        assign rel_hit[gi] = (cnt_inc == CNT_W'(gi * STAGGER));
    end

    // State, shared counter, reset outputs and cycle counter; reset forces the idle-hold values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            rst_q   <= '1;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic for the hold/release/run sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d    = '0;
                    rst_d[0] = 1'b0;
                    // With a single channel its release is also the last one.
                    state_d  = (N_CH == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RELEASE: begin
                cnt_d = cnt_inc;
                rst_d = rst_q & ~rel_hit;
                if (cnt_inc == REL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A halt on the limit cycle still counts as a clean finish.
                if (halt_i) begin
                    state_d = ST_DONE;
                    rst_d   = '1;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = ST_TIMEOUT;
                    cyc_d   = CYC_LIMIT;
                    rst_d   = '1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    cyc_d   = '0;
                    rst_d   = '1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                cyc_d   = '0;
                rst_d   = '1;
            end
        endcase
    end

    assign rst_o     = rst_q;
    assign running   = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign timeout   = (state_q == ST_TIMEOUT);
    assign cycle_cnt = cyc_q;

endmodule : run_ctrl

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning the number of independent reset channels (N_CH >= 1).
REQ-002 SHALL have parameter HOLD_CYC, default 4, meaning the clock cycles held in reset after `reset` deasserts (HOLD_CYC >= 1).
REQ-003 SHALL have parameter STAGGER, default 2, meaning the cycles between successive channel releases (STAGGER >= 1).
REQ-004 SHALL have parameter MAX_CYC, default 500, meaning the run-cycle limit before timeout (MAX_CYC >= 2).
REQ-005 SHALL have parameter CW, default 32, meaning the cycle counter width; CW >= clog2(MAX_CYC+1) is enforced by an elaboration-time check.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port start, input, 1, a re-run request sampled at each rising edge.
REQ-009 SHALL have port halt_i, input, 1, the processor-finished indication.
REQ-010 SHALL have port rst_o, output, N_CH, per-channel registered active-high reset.
REQ-011 SHALL have port running, output, 1, high only in state RUN.
REQ-012 SHALL have port done, output, 1, high only in state DONE.
REQ-013 SHALL have port timeout, output, 1, high only in state TIMEOUT.
REQ-014 SHALL have port cycle_cnt, output, CW, the count of completed RUN cycles.

Function
REQ-015 SHALL implement the states HOLD, RELEASE, RUN, DONE and TIMEOUT.
REQ-016 HOLD SHALL last exactly HOLD_CYC cycles, then move to RELEASE with the release counter at 0.
REQ-017 rst_o[k] SHALL deassert exactly HOLD_CYC + k*STAGGER rising edges after `reset` deasserts; channel 0 deasserts first.
REQ-018 Once deasserted, a channel SHALL stay low until DONE, TIMEOUT or `reset`.
REQ-019 RELEASE SHALL move to RUN on the edge that deasserts rst_o[N_CH-1], so `running` rises together with the last release.
REQ-020 In RUN, each edge: if halt_i=1, go to DONE and hold cycle_cnt; else if cycle_cnt == MAX_CYC-1, go to TIMEOUT with cycle_cnt <= MAX_CYC; else cycle_cnt increments.
REQ-021 If halt_i and the limit coincide, halt_i SHALL win: the block enters DONE and timeout stays 0.
REQ-022 cycle_cnt SHALL read 0 in the first RUN cycle, never wrap, and never exceed MAX_CYC.
REQ-023 Entering DONE or TIMEOUT SHALL reassert all rst_o bits on the same edge; cycle_cnt SHALL freeze.
REQ-024 start=1 in DONE or TIMEOUT SHALL go to HOLD, clear cycle_cnt and flags, and repeat the REQ-016..019 sequence, timed from that edge.
REQ-025 start SHALL be ignored in HOLD, RELEASE and RUN.
REQ-026 halt_i SHALL be ignored outside RUN.

Reset
REQ-027 `reset`=1 SHALL immediately force state HOLD, rst_o all ones, running=done=timeout=0, cycle_cnt=0, and internal counters 0.
REQ-028 `reset` asserted mid-RELEASE or mid-RUN SHALL abort the sequence with no partial outputs; release timing restarts from deassertion.

Structure
REQ-029 The state enum typedef and the default parameter constants SHALL reside in shared package run_ctrl_pkg.
REQ-030 The block SHALL be a single module with no sub-modules: one state register, one shared hold/release counter, and the cycle counter.

Verification (defaults, 10 ns clock)
REQ-031 Release: deassert reset at edge 0 -> rst_o[0] falls at edge 4, rst_o[1] falls at edge 6, running=1 from edge 6.
REQ-032 Halt: halt_i=1 in the RUN cycle where cycle_cnt=37 -> done=1 next edge, cycle_cnt holds 37, rst_o=2'b11.
REQ-033 Timeout: halt_i held 0 -> after 500 RUN edges timeout=1, cycle_cnt=500, rst_o=2'b11, running=0.
REQ-034 Coincidence: halt_i=1 when cycle_cnt=499 -> done=1, timeout=0, cycle_cnt=499.
REQ-035 Re-run: pulse start one cycle in DONE -> cycle_cnt=0, flags clear, rst_o[0] falls 4 edges and rst_o[1] 6 edges later; start pulsed during RUN -> no effect.
REQ-036 Async reset: assert reset mid-cycle during RUN -> outputs reach reset values before the next edge; release repeats per REQ-031.
